// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 held-key state with HPS joysticks, then rotates, SOCD-cleans and coin-stretches per player.
// Optional autofire is compiled in when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
  parameter int PLAYERS    = 2,
  parameter int COIN_PULSE = 1200000
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  , parameter int AUTOFIRE_PERIOD = 200000
`endif
) (
  input  logic                  clk_sys,
  input  logic                  RESET_N,
  input  logic [10:0]           ps2_key,
  input  logic [16*PLAYERS-1:0] joystick,
  input  logic [1:0]            rotate,
  input  logic                  socd_en,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  input  logic [PLAYERS-1:0]    autofire,
`endif
  output logic [7*PLAYERS-1:0]  csjudlr
);

  localparam int KEYS = 15;
  localparam int CW   = $clog2(COIN_PULSE + 1);

  logic            old_toggle;
  logic [KEYS-1:0] key_state;
  logic [KEYS-1:0] key_hit;
  logic [6:0]      key_p0;
  logic [6:0]      key_p1;
  logic            unused_inputs;

  // Key slots: 0-7 player 0 {up,down,left,right,fire_a,fire_b,start,coin}, 8-14 player 1 {up,down,left,right,fire,start,coin}
  always_comb begin
    key_hit = '0;
    case (ps2_key[7:0])
      8'h75: key_hit[0]  = 1'b1;
      8'h72: key_hit[1]  = 1'b1;
      8'h6B: key_hit[2]  = 1'b1;
      8'h74: key_hit[3]  = 1'b1;
      8'h29: key_hit[4]  = 1'b1;
      8'h14: key_hit[5]  = 1'b1;
      8'h05: key_hit[6]  = 1'b1;
      8'h2E: key_hit[7]  = 1'b1;
      8'h2D: key_hit[8]  = 1'b1;
      8'h2B: key_hit[9]  = 1'b1;
      8'h23: key_hit[10] = 1'b1;
      8'h34: key_hit[11] = 1'b1;
      8'h1C: key_hit[12] = 1'b1;
      8'h06: key_hit[13] = 1'b1;
      8'h36: key_hit[14] = 1'b1;
      default: key_hit = '0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      old_toggle <= 1'b0;
      key_state  <= '0;
    end else begin
      old_toggle <= ps2_key[10];
      if (ps2_key[10] != old_toggle) begin
        for (int k = 0; k < KEYS; k++) begin
          if (key_hit[k]) key_state[k] <= ps2_key[9];
        end
      end
    end
  end

  // Per-player vectors in output order {coin, start, fire, up, down, left, right}
  assign key_p0 = {key_state[7], key_state[6], key_state[4] | key_state[5],
                   key_state[0], key_state[1], key_state[2], key_state[3]};
  assign key_p1 = {key_state[14], key_state[13], key_state[12],
                   key_state[8], key_state[9], key_state[10], key_state[11]};

  assign unused_inputs = ps2_key[8] ^ (^key_p1);

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    logic [15:0]   joy;
    logic [6:0]    keys;
    logic [6:0]    raw;
    logic [3:0]    rot;
    logic [3:0]    clean;
    logic          coin_prev;
    logic [CW-1:0] coin_cnt;
    logic          fire_out;
    logic [6:0]    out_q;
    logic          unused_joy;

    assign joy        = joystick[16*p +: 16];
    assign unused_joy = ^{joy[15:8], joy[6]};

    if (p == 0) begin : g_keys0
      assign keys = key_p0;
    end else if (p == 1) begin : g_keys1
      assign keys = key_p1;
    end else begin : g_keys_none
      assign keys = '0;
    end

    assign raw = keys | {joy[7], joy[5], joy[4], joy[3], joy[2], joy[1], joy[0]};

    // rot/raw low nibble is {up, down, left, right}
    always_comb begin
      rot = raw[3:0];
      case (rotate)
        2'd1:    rot = {raw[1], raw[0], raw[2], raw[3]};
        2'd2:    rot = {raw[0], raw[1], raw[3], raw[2]};
        2'd3:    rot = {raw[2], raw[3], raw[0], raw[1]};
        default: rot = raw[3:0];
      endcase
    end

    assign clean[3:2] = (socd_en && rot[3] && rot[2]) ? 2'b00 : rot[3:2];
    assign clean[1:0] = (socd_en && rot[1] && rot[0]) ? 2'b00 : rot[1:0];

    // Counter only rearms at zero, so edges during a pulse are dropped
    always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
        coin_prev <= 1'b0;
        coin_cnt  <= '0;
      end else begin
        coin_prev <= raw[6];
        if (coin_cnt != '0) begin
          coin_cnt <= coin_cnt - CW'(1);
        end else if (raw[6] && !coin_prev) begin
          coin_cnt <= CW'(COIN_PULSE);
        end
      end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AW = (AUTOFIRE_PERIOD > 1) ? $clog2(AUTOFIRE_PERIOD) : 1;
    logic [AW-1:0] af_cnt;
    logic          af_on;

    // Phase restarts high whenever fire is released
    always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
        af_cnt <= AW'(AUTOFIRE_PERIOD - 1);
        af_on  <= 1'b1;
      end else if (!raw[4]) begin
        af_cnt <= AW'(AUTOFIRE_PERIOD - 1);
        af_on  <= 1'b1;
      end else if (af_cnt == '0) begin
        af_cnt <= AW'(AUTOFIRE_PERIOD - 1);
        af_on  <= ~af_on;
      end else begin
        af_cnt <= af_cnt - AW'(1);
      end
    end

    assign fire_out = raw[4] & (~autofire[p] | af_on);
`else
    assign fire_out = raw[4];
`endif

    always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
        out_q <= '0;
      end else begin
        out_q <= {coin_cnt != '0, raw[5], fire_out, clean};
      end
    end

    assign csjudlr[7*p +: 7] = out_q;
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed plus randomized bench for arcade_input_mapper against a direction-index reference model.
module tb_arcade_input_mapper;
  localparam int PLAYERS    = 2;
  localparam int COIN_PULSE = 4;

  logic                  clk_sys = 1'b0;
  logic                  RESET_N;
  logic [10:0]           ps2_key;
  logic [16*PLAYERS-1:0] joystick;
  logic [1:0]            rotate;
  logic                  socd_en;
  logic [7*PLAYERS-1:0]  csjudlr;

  int checks = 0;
  int fails  = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper #(.PLAYERS(PLAYERS), .COIN_PULSE(COIN_PULSE)) dut (
    .clk_sys (clk_sys),
    .RESET_N (RESET_N),
    .ps2_key (ps2_key),
    .joystick(joystick),
    .rotate  (rotate),
    .socd_en (socd_en),
    .csjudlr (csjudlr)
  );

  // Functions indexed clockwise: 0 up, 1 right, 2 down, 3 left, then 4 fire, 5 start, 6 coin
  int          jbit   [7] = '{3, 0, 2, 1, 4, 5, 7};
  logic [7:0]  code0  [7] = '{8'h75, 8'h74, 8'h72, 8'h6B, 8'h29, 8'h05, 8'h2E};
  logic [7:0]  code1  [7] = '{8'h2D, 8'h34, 8'h2B, 8'h23, 8'h1C, 8'h06, 8'h36};
  logic [7:0]  rcodes [18] = '{8'h75, 8'h74, 8'h72, 8'h6B, 8'h29, 8'h14, 8'h05, 8'h2E,
                               8'h2D, 8'h34, 8'h2B, 8'h23, 8'h1C, 8'h06, 8'h36,
                               8'h1A, 8'h00, 8'hF0};

  bit                   held [0:255];
  bit                   m_tog;
  int                   coin_left [PLAYERS];
  bit                   coin_prev [PLAYERS];
  logic [7*PLAYERS-1:0] exp_out;

  function automatic bit phys(input int p, input int fn);
    bit k;
    k = 1'b0;
    if (p == 0) begin
      k = held[code0[fn]];
      if (fn == 4) k = k | held[8'h14];
    end else if (p == 1) begin
      k = held[code1[fn]];
    end
    return k | joystick[16*p + jbit[fn]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) held[i] = 1'b0;
    m_tog = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      coin_left[p] = 0;
      coin_prev[p] = 1'b0;
    end
    exp_out = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare the whole output
  task automatic tick(input string tag);
    logic [7*PLAYERS-1:0] nxt;
    bit                   req;
    @(posedge clk_sys);
    if (!RESET_N) begin
      model_reset();
    end else begin
      nxt = '0;
      for (int p = 0; p < PLAYERS; p++) begin
        bit l [4];
        int sh;
        sh = (rotate == 2'd1) ? 3 : (rotate == 2'd2) ? 1 : (rotate == 2'd3) ? 2 : 0;
        for (int d = 0; d < 4; d++) l[d] = phys(p, (d + sh) % 4);
        if (socd_en && l[0] && l[2]) begin l[0] = 1'b0; l[2] = 1'b0; end
        if (socd_en && l[1] && l[3]) begin l[1] = 1'b0; l[3] = 1'b0; end
        nxt[7*p +: 7] = {coin_left[p] > 0, phys(p, 5), phys(p, 4), l[0], l[2], l[3], l[1]};
      end
      for (int p = 0; p < PLAYERS; p++) begin
        req = phys(p, 6);
        if (coin_left[p] > 0) coin_left[p]--;
        else if (req && !coin_prev[p]) coin_left[p] = COIN_PULSE;
        coin_prev[p] = req;
      end
      if (ps2_key[10] != m_tog) held[ps2_key[7:0]] = ps2_key[9];
      m_tog   = ps2_key[10];
      exp_out = nxt;
    end
    #1;
    check(tag, 32'(csjudlr), 32'(exp_out));
  endtask

  initial begin
    bit         tog;
    int         hi;
    logic [7:0] code;
    bit         press;

    model_reset();
    tog      = 1'b0;
    RESET_N  = 1'b0;
    ps2_key  = 11'h275;
    joystick = 32'h0020_0011;
    rotate   = 2'd0;
    socd_en  = 1'b0;

    repeat (3) tick("reset_hold");
    check("reset_zero", 32'(csjudlr), 32'h0);
    RESET_N = 1'b1;
    tick("reset_rel1");
    tick("reset_rel2");
    check("reset_follow_p0", 32'(csjudlr[6:0]), 32'h11);
    check("reset_follow_p1", 32'(csjudlr[13:7]), 32'h20);

    joystick = '0;
    tick("idle");
    tog = 1'b1;
    ps2_key = {tog, 10'h275};
    tick("key_press1");
    check("key_up_not_yet", 32'(csjudlr[3]), 32'h0);
    tick("key_press2");
    check("key_up_set", 32'(csjudlr[3]), 32'h1);
    tog = 1'b0;
    ps2_key = {tog, 10'h075};
    tick("key_rel1");
    tick("key_rel2");
    check("key_up_clear", 32'(csjudlr[3]), 32'h0);

    tog = 1'b1;
    ps2_key = {tog, 1'b1, 1'b1, 8'h1C};
    tick("ext_key1");
    tick("ext_key2");
    check("ext_p1_fire", 32'(csjudlr[11]), 32'h1);
    tog = 1'b0;
    ps2_key = {tog, 1'b0, 1'b0, 8'h1C};
    tick("ext_rel1");
    tick("ext_rel2");

    joystick[1] = 1'b1;
    rotate = 2'd1;
    tick("rot_cw");
    check("rot_cw_left", 32'(csjudlr[6:0]), 32'b0001000);
    rotate = 2'd3;
    tick("rot_180");
    check("rot_180_left", 32'(csjudlr[6:0]), 32'b0000001);
    rotate = 2'd2;
    tick("rot_ccw");
    check("rot_ccw_left", 32'(csjudlr[6:0]), 32'b0000100);
    rotate = 2'd0;
    tick("rot_none");
    check("rot_none_left", 32'(csjudlr[6:0]), 32'b0000010);

    joystick = '0;
    joystick[19] = 1'b1;
    joystick[18] = 1'b1;
    socd_en = 1'b1;
    tick("socd_on");
    check("socd_on_ud", 32'(csjudlr[10:9]), 32'h0);
    socd_en = 1'b0;
    tick("socd_off");
    check("socd_off_ud", 32'(csjudlr[10:9]), 32'h3);
    joystick = '0;
    tick("idle2");

    hi = 0;
    joystick[23] = 1'b1;
    tick("coin_single"); hi += int'(csjudlr[13]);
    joystick[23] = 1'b0;
    repeat (9) begin tick("coin_single"); hi += int'(csjudlr[13]); end
    check("coin_single_width", 32'(hi), 32'(COIN_PULSE));

    hi = 0;
    joystick[23] = 1'b1;
    tick("coin_retrig"); hi += int'(csjudlr[13]);
    joystick[23] = 1'b0;
    tick("coin_retrig"); hi += int'(csjudlr[13]);
    joystick[23] = 1'b1;
    tick("coin_retrig"); hi += int'(csjudlr[13]);
    joystick[23] = 1'b0;
    repeat (9) begin tick("coin_retrig"); hi += int'(csjudlr[13]); end
    check("coin_retrig_width", 32'(hi), 32'(COIN_PULSE));

    hi = 0;
    joystick[23] = 1'b1;
    repeat (10) begin tick("coin_held"); hi += int'(csjudlr[13]); end
    joystick[23] = 1'b0;
    repeat (5) begin tick("coin_held"); hi += int'(csjudlr[13]); end
    check("coin_held_width", 32'(hi), 32'(COIN_PULSE));

    joystick[7] = 1'b1;
    tick("coin_abort");
    joystick[7] = 1'b0;
    tick("coin_abort");
    check("coin_abort_high", 32'(csjudlr[6]), 32'h1);
    RESET_N = 1'b0;
    #1;
    check("coin_abort_async", 32'(csjudlr), 32'h0);
    tick("coin_abort_rst");
    RESET_N = 1'b1;
    hi = 0;
    repeat (6) begin tick("coin_abort_after"); hi += int'(csjudlr[6]); end
    check("coin_abort_gone", 32'(hi), 32'h0);

    for (int i = 0; i < 600; i++) begin
      joystick = (16*PLAYERS)'($urandom);
      if ($urandom_range(0, 5) != 0) joystick[7] = 1'b0;
      if ($urandom_range(0, 5) != 0) joystick[23] = 1'b0;
      if ($urandom_range(0, 9) == 0) rotate = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) socd_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        tog   = ~tog;
        code  = rcodes[$urandom_range(0, 17)];
        press = 1'($urandom_range(0, 1));
        ps2_key = {tog, press, 1'($urandom_range(0, 1)), code};
      end else begin
        ps2_key[8:0] = 9'($urandom);
      end
      if (i == 300) begin
        RESET_N = 1'b0;
        tick("rand_reset");
        RESET_N = 1'b1;
        tog = ps2_key[10];
      end
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
